// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared types for the fc output-side blocks. Holds the
//                argmax sink state encoding and the default-width signed
//                element type used between the fc datapath and its sinks.
//  Revision    : 1.0  initial release
// ============================================================================
package fc_pkg;

   localparam int FC_M_DEFAULT = 16;
   localparam int FC_T_DEFAULT = 20;

   // Signed fc element at the default width; modules that take T as a
   // parameter declare logic signed [T-1:0] of the same shape.
   typedef logic signed [FC_T_DEFAULT-1:0] fc_data_t;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } argmax_state_t;

endpackage : fc_pkg
`default_nettype wire

// File: rtl/argmax_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_cmp
//  Description : Combinational "new > best" signed compare with select.
//                Produces the winning {value, index} pair for one step of a
//                running argmax. first_i forces the new element to win so
//                the first element of a vector loads unconditionally.
//  Ports       : first_i    - new element is the first of its vector
//                new_val_i  - incoming signed element
//                new_idx_i  - position of incoming element
//                best_val_i - current best value
//                best_idx_i - position of current best
//                win_val_o  - selected value
//                win_idx_o  - selected position
//  Revision    : 1.0  initial release
// ============================================================================
module argmax_cmp
   import fc_pkg::*;
#(
   parameter int T  = 20,
   parameter int IW = 4
) (
   input  logic                 first_i,
   input  logic signed [T-1:0]  new_val_i,
   input  logic        [IW-1:0] new_idx_i,
   input  logic signed [T-1:0]  best_val_i,
   input  logic        [IW-1:0] best_idx_i,
   output logic signed [T-1:0]  win_val_o,
   output logic        [IW-1:0] win_idx_o
);

   logic take_new;

   // Strictly greater: on a tie the earlier (lower) index is kept.
   assign take_new  = first_i || (new_val_i > best_val_i);
   assign win_val_o = take_new ? new_val_i : best_val_i;
   assign win_idx_o = take_new ? new_idx_i : best_idx_i;

endmodule : argmax_cmp
`default_nettype wire

// File: rtl/fc_argmax_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fc_argmax_sink
//  Description : Stream sink for the fc layer output. Accepts M signed
//                elements over a valid/ready handshake, tracks the running
//                maximum and its position, and presents {index, max} on a
//                valid/ready output one cycle after the M-th element. The
//                result is held until accepted; input is stalled meanwhile.
//  Ports       : clk          - rising-edge clock
//                reset        - synchronous active-high reset
//                input_valid  - upstream element available
//                input_ready  - element accepted this cycle
//                input_data   - signed element
//                output_valid - result available
//                output_ready - downstream accepts result
//                output_index - position of the maximum (0..M-1)
//                output_max   - maximum value
//  Revision    : 1.0  initial release
// ============================================================================
module fc_argmax_sink
   import fc_pkg::*;
#(
   parameter int M = 16,
   parameter int T = 20,
   localparam int LOGSIZE_M = $clog2(M)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        input_valid,
   output logic                        input_ready,
   input  logic signed [T-1:0]         input_data,
   output logic                        output_valid,
   input  logic                        output_ready,
   output logic        [LOGSIZE_M-1:0] output_index,
   output logic signed [T-1:0]         output_max
);

   localparam logic [LOGSIZE_M-1:0] CNT_LAST = LOGSIZE_M'(M - 1);
   localparam logic [LOGSIZE_M-1:0] CNT_ONE  = LOGSIZE_M'(1);

   argmax_state_t                state_q;
   logic          [LOGSIZE_M-1:0] cnt_q;
   logic          [LOGSIZE_M-1:0] best_idx_q;
   logic signed   [T-1:0]         best_val_q;
   logic          [LOGSIZE_M-1:0] out_idx_q;
   logic signed   [T-1:0]         out_max_q;

   logic          [LOGSIZE_M-1:0] best_idx_d;
   logic signed   [T-1:0]         best_val_d;
   logic                          in_xfer;

   // Handshake flags come from the registered state only. input_ready is
   // additionally held low while reset is asserted so nothing is accepted
   // during reset; it rises in the first cycle reset is low.
   assign input_ready  = (state_q == COLLECT) && !reset;
   assign output_valid = (state_q == HOLD);
   assign output_index = out_idx_q;
   assign output_max   = out_max_q;

   assign in_xfer = input_valid && input_ready;

   argmax_cmp #(
      .T  (T),
      .IW (LOGSIZE_M)
   ) u_cmp (
      .first_i    (cnt_q == '0),
      .new_val_i  (input_data),
      .new_idx_i  (cnt_q),
      .best_val_i (best_val_q),
      .best_idx_i (best_idx_q),
      .win_val_o  (best_val_d),
      .win_idx_o  (best_idx_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= COLLECT;
         cnt_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         out_idx_q  <= '0;
         out_max_q  <= '0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_xfer) begin
                  best_val_q <= best_val_d;
                  best_idx_q <= best_idx_d;
                  // Last element: the compare including this element goes
                  // straight into the result registers, and the counter
                  // wraps at M-1 rather than at its natural power of two.
                  if (cnt_q == CNT_LAST) begin
                     out_max_q <= best_val_d;
                     out_idx_q <= best_idx_d;
                     cnt_q     <= '0;
                     state_q   <= HOLD;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            HOLD: begin
               if (output_ready) begin
                  state_q <= COLLECT;
               end
            end
         endcase
      end
   end

endmodule : fc_argmax_sink
`default_nettype wire

// File: tb/tb_fc_argmax_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_argmax_sink
//  Description : Self-checking bench for fc_argmax_sink. Elements accepted
//                by the DUT are compared against an argmax computed from
//                the stimulus vector with a plain loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fc_argmax_sink;

   localparam int M  = 16;
   localparam int T  = 20;
   localparam int LW = 4;

   typedef logic signed [T-1:0] data_t;

   logic           clk = 1'b0;
   logic           reset;
   logic           input_valid;
   logic           input_ready;
   data_t          input_data;
   logic           output_valid;
   logic           output_ready;
   logic  [LW-1:0] output_index;
   data_t          output_max;

   int errors = 0;
   int checks = 0;

   data_t vec [M];

   always #5 clk = ~clk;

   fc_argmax_sink #(.M(M), .T(T)) dut (
      .clk          (clk),
      .reset        (reset),
      .input_valid  (input_valid),
      .input_ready  (input_ready),
      .input_data   (input_data),
      .output_valid (output_valid),
      .output_ready (output_ready),
      .output_index (output_index),
      .output_max   (output_max)
   );

   // Reference: first position holding the largest value in vec.
   task automatic ref_argmax(output logic [LW-1:0] idx, output data_t mx);
      int bi = 0;
      for (int i = 1; i < M; i++) begin
         if (vec[i] > vec[bi]) bi = i;
      end
      idx = LW'(bi);
      mx  = vec[bi];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers vec[] to the DUT, with random idle cycles at gap_pct percent.
   // Returns 1ns after the edge that accepted the last element.
   task automatic drive_vector(input int gap_pct, output int cycles);
      int  k = 0;
      logic rdy;
      cycles = 0;
      while (k < M && cycles < 2000) begin
         if (int'($urandom_range(99)) < gap_pct) begin
            input_valid = 1'b0;
            input_data  = data_t'($urandom);
         end else begin
            input_valid = 1'b1;
            input_data  = vec[k];
         end
         rdy = input_ready;
         @(posedge clk);
         if (input_valid && rdy) k++;
         #1;
         cycles++;
      end
      input_valid = 1'b0;
      input_data  = '0;
      checks++;
      if (k != M) begin
         errors++;
         $display("FAIL drive_timeout: accepted %0d elements, required %0d", k, M);
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      input_valid  = 1'b1;
      input_data   = 20'sd1234;
      output_ready = 1'b0;
      tick();
      tick();
      checks++;
      if (input_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", input_ready); end
      checks++;
      if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", output_valid); end
      checks++;
      if (output_index !== '0) begin errors++; $display("FAIL reset_index: got %0d want 0", output_index); end
      checks++;
      if (output_max !== '0) begin errors++; $display("FAIL reset_max: got %0d want 0", output_max); end
      input_valid = 1'b0;
      reset       = 1'b0;
      #1;
      checks++;
      if (input_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", input_ready); end
   endtask

   task automatic test_ascending();
      int cyc;
      for (int i = 0; i < M; i++) vec[i] = data_t'(i);
      output_ready = 1'b1;
      drive_vector(0, cyc);
      checks++;
      if (output_valid !== 1'b1) begin errors++; $display("FAIL asc_latency: valid got %b want 1", output_valid); end
      checks++;
      if (output_index !== 4'd15) begin errors++; $display("FAIL asc_index: got %0d want 15", output_index); end
      checks++;
      if (output_max !== 20'sd15) begin errors++; $display("FAIL asc_max: got %0d want 15", output_max); end
      checks++;
      if (input_ready !== 1'b0) begin errors++; $display("FAIL asc_stall: ready got %b want 0", input_ready); end
      tick();
      checks++;
      if (output_valid !== 1'b0) begin errors++; $display("FAIL asc_one_cycle: valid got %b want 0", output_valid); end
   endtask

   task automatic run_and_check(input string name, input int gap_pct);
      int           cyc;
      logic [LW-1:0] ei;
      data_t        em;
      ref_argmax(ei, em);
      output_ready = 1'b1;
      drive_vector(gap_pct, cyc);
      checks++;
      if (output_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, output_valid); end
      checks++;
      if (output_index !== ei) begin errors++; $display("FAIL %s_index: got %0d want %0d", name, output_index, ei); end
      checks++;
      if (output_max !== em) begin errors++; $display("FAIL %s_max: got %0d want %0d", name, output_max, em); end
      tick();
   endtask

   task automatic test_ties();
      for (int i = 0; i < M; i++) vec[i] = -20'sd5;
      vec[7] = -20'sd1;
      vec[3] = 20'sd300;
      vec[9] = 20'sd300;
      run_and_check("ties", 0);
      // Independent of the model: the spec'd answer for this pattern.
      checks++;
      if (output_max !== 20'sd300 || output_index !== 4'd3) begin
         errors++;
         $display("FAIL ties_const: got idx %0d max %0d want idx 3 max 300", output_index, output_max);
      end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < M; i++) vec[i] = -20'sd524288;
      run_and_check("most_neg", 0);
      for (int i = 0; i < M; i++) vec[i] = '0;
      vec[12] = 20'sd524287;
      run_and_check("most_pos", 0);
   endtask

   task automatic test_random_stall();
      int           cyc;
      logic [LW-1:0] ei;
      data_t        em;
      for (int i = 0; i < M; i++) vec[i] = data_t'($urandom);
      ref_argmax(ei, em);
      output_ready = 1'b0;
      drive_vector(50, cyc);
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (output_valid !== 1'b1 || input_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_flags c%0d: valid %b ready %b want valid 1 ready 0", c, output_valid, input_ready);
         end
         checks++;
         if (output_index !== ei || output_max !== em) begin
            errors++;
            $display("FAIL stall_hold c%0d: idx %0d max %0d want idx %0d max %0d", c, output_index, output_max, ei, em);
         end
         input_valid = 1'b1;
         input_data  = 20'sd524287;
         tick();
      end
      input_valid  = 1'b0;
      output_ready = 1'b1;
      tick();
      checks++;
      if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: valid %b ready %b want valid 0 ready 1", output_valid, input_ready);
      end
      for (int i = 0; i < M; i++) vec[i] = data_t'($urandom);
      run_and_check("after_stall", 50);
   endtask

   task automatic test_reset_midvector();
      int cyc;
      for (int i = 0; i < M; i++) vec[i] = 20'sd1000 + data_t'(i);
      // Feed only the first half, then reset.
      for (int k = 0; k < 8; k++) begin
         input_valid = 1'b1;
         input_data  = vec[k];
         tick();
      end
      reset      = 1'b1;
      input_data = 20'sd2000;
      tick();
      checks++;
      if (input_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", input_ready); end
      tick();
      reset       = 1'b0;
      input_valid = 1'b0;
      #1;
      for (int i = 0; i < M; i++) vec[i] = data_t'($urandom_range(100)) - 20'sd50;
      vec[2] = 20'sd77;
      run_and_check("midrst", 0);
      cyc = 0;
   endtask

   task automatic test_back_to_back();
      int           cyc;
      logic [LW-1:0] ei;
      data_t        em;
      output_ready = 1'b1;
      for (int v = 0; v < 2; v++) begin
         for (int i = 0; i < M; i++) vec[i] = data_t'($urandom);
         ref_argmax(ei, em);
         drive_vector(0, cyc);
         checks++;
         if (cyc != M) begin errors++; $display("FAIL b2b_cycles v%0d: got %0d want %0d", v, cyc, M); end
         checks++;
         if (output_valid !== 1'b1 || output_index !== ei || output_max !== em) begin
            errors++;
            $display("FAIL b2b_result v%0d: valid %b idx %0d max %0d want idx %0d max %0d",
                     v, output_valid, output_index, output_max, ei, em);
         end
         checks++;
         if (input_ready !== 1'b0) begin errors++; $display("FAIL b2b_bubble v%0d: ready got %b want 0", v, input_ready); end
         tick();
         checks++;
         if (input_ready !== 1'b1 || output_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_resume v%0d: ready %b valid %b want ready 1 valid 0", v, input_ready, output_valid);
         end
      end
   endtask

   initial begin
      reset        = 1'b1;
      input_valid  = 1'b0;
      input_data   = '0;
      output_ready = 1'b0;
      test_reset();
      test_ascending();
      test_ties();
      test_extremes();
      test_random_stall();
      test_reset_midvector();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fc_argmax_sink
`default_nettype wire
